// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory stage: access size encoding, the
// request FSM states, the wait-counter width and the EX/MEM register layout.
package memory_access_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [0:0] {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } mem_state_t;

  // Wide enough for any timeout in 1..255.
  localparam int CNT_W = 8;

  // EX/MEM pipeline register contents.
  typedef struct packed {
    logic        valid;
    logic        mem_read;
    logic        mem_write;
    mem_size_t   size;
    logic        is_unsigned;
    logic        jump;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [31:0] pc_plus4;
  } ex_mem_t;

endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge port.
//   req/we/addr/byte_en/wdata : driven by the memory stage (master)
//   ack/rdata                 : driven by the memory (slave); rdata is valid with ack
interface memory_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, byte_en, wdata, input ack, rdata);
  modport slave  (input req, we, addr, byte_en, wdata, output ack, rdata);
endinterface

// File: rtl/memory_access_load_store_align.sv
// Combinational lane logic for loads and stores.
//   size, is_unsigned, addr_lo : access width, extension mode, low address bits
//   store_data                 : rs2 value to be written
//   rdata                      : raw word returned by memory
//   byte_en, wdata             : lane enables and lane-replicated store data
//   load_data                  : selected byte/half/word, sign- or zero-extended
//   misaligned                 : access crosses its natural alignment
module load_store_align
  import memory_access_pkg::*;
(
  input  mem_size_t   size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  rd_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = rdata[8*gi +: 8];
  end

  always_comb begin
    byte_en    = 4'b1111;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b0;
    byte_sel   = rd_lane[addr_lo];
    half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      MEM_HALF: begin
        misaligned = addr_lo[0];
        byte_en    = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        load_data  = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      default: begin
        // Word access (the unused encoding is treated as a word too).
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage of the RV32I pipeline.
//   CLK, RST        : clock and synchronous active-high reset
//   *_E             : instruction fields from execute, captured into EX/MEM
//   Stall_M         : freezes IF..EX and EX/MEM while memory is outstanding
//   dmem            : data-memory req/ack port
//   *_W             : MEM/WB register outputs towards writeback
module memory_access
  import memory_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Valid_E,
  input  logic                  Mem_Read_E,
  input  logic                  Mem_Write_E,
  input  logic [1:0]            Mem_Size_E,
  input  logic                  Mem_Unsigned_E,
  input  logic                  Jump_E,
  input  logic                  Reg_Write_E,
  input  logic [4:0]            RD_E,
  input  logic [31:0]           ALU_Out_E,
  input  logic [31:0]           Store_Data_E,
  input  logic [31:0]           PC_Plus4_E,
  output logic                  Stall_M,
  memory_access_if.master       dmem,
  output logic                  Valid_W,
  output logic                  Reg_Write_W,
  output logic [4:0]            RD_W,
  output logic [31:0]           Result_W,
  output logic                  Misaligned_Exc_W,
  output logic                  Bus_Err_W
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  ex_mem_t          ex_mem_reg, ex_mem_next;
  mem_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic        req, stall, timeout;
  logic        misaligned, mem_op, mis_exc;
  logic [3:0]  lane_en;
  logic [31:0] lane_wdata, load_data, result_next;

  logic        valid_w_reg, reg_write_w_reg, misaligned_w_reg, bus_err_w_reg;
  logic [4:0]  rd_w_reg;
  logic [31:0] result_w_reg;

  load_store_align u_align (
    .size        (ex_mem_reg.size),
    .is_unsigned (ex_mem_reg.is_unsigned),
    .addr_lo     (ex_mem_reg.alu_out[1:0]),
    .store_data  (ex_mem_reg.store_data),
    .rdata       (dmem.rdata),
    .byte_en     (lane_en),
    .wdata       (lane_wdata),
    .load_data   (load_data),
    .misaligned  (misaligned)
  );

  always_comb begin
    ex_mem_next.valid       = Valid_E;
    ex_mem_next.mem_read    = Mem_Read_E;
    ex_mem_next.mem_write   = Mem_Write_E;
    ex_mem_next.size        = mem_size_t'(Mem_Size_E);
    ex_mem_next.is_unsigned = Mem_Unsigned_E;
    ex_mem_next.jump        = Jump_E;
    ex_mem_next.reg_write   = Reg_Write_E;
    ex_mem_next.rd          = RD_E;
    ex_mem_next.alu_out     = ALU_Out_E;
    ex_mem_next.store_data  = Store_Data_E;
    ex_mem_next.pc_plus4    = PC_Plus4_E;
  end

  assign mis_exc = ex_mem_reg.valid & (ex_mem_reg.mem_read | ex_mem_reg.mem_write) & misaligned;
  assign mem_op  = ex_mem_reg.valid & (ex_mem_reg.mem_read | ex_mem_reg.mem_write) & ~misaligned;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_mem_reg <= '0;
      state_reg  <= MS_IDLE;
      cnt_reg    <= '0;
    end else begin
      if (!stall) ex_mem_reg <= ex_mem_next;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req        = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      MS_IDLE: begin
        req = mem_op;
        if (mem_op && !dmem.ack) begin
          state_next = MS_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      MS_WAIT: begin
        // The timeout cycle drops the request, so an ack arriving then is ignored.
        if (cnt_reg == TIMEOUT_CNT) begin
          timeout    = 1'b1;
          state_next = MS_IDLE;
          cnt_next   = '0;
        end else begin
          req = 1'b1;
          if (dmem.ack) begin
            state_next = MS_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = MS_IDLE;
        cnt_next   = '0;
      end
    endcase
    // Withdraw the request in the very cycle reset is sampled.
    if (RST) req = 1'b0;
  end

  assign stall = req & ~dmem.ack;

  always_comb begin
    result_next = ex_mem_reg.alu_out;
    if (ex_mem_reg.mem_read)  result_next = load_data;
    else if (ex_mem_reg.jump) result_next = ex_mem_reg.pc_plus4;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_w_reg      <= 1'b0;
      reg_write_w_reg  <= 1'b0;
      misaligned_w_reg <= 1'b0;
      bus_err_w_reg    <= 1'b0;
      rd_w_reg         <= '0;
      result_w_reg     <= '0;
    end else if (stall) begin
      // Bubble into writeback; rd/result keep stale values.
      valid_w_reg      <= 1'b0;
      reg_write_w_reg  <= 1'b0;
      misaligned_w_reg <= 1'b0;
      bus_err_w_reg    <= 1'b0;
    end else begin
      valid_w_reg      <= ex_mem_reg.valid;
      reg_write_w_reg  <= ex_mem_reg.reg_write & ex_mem_reg.valid & ~mis_exc & ~timeout;
      misaligned_w_reg <= mis_exc;
      bus_err_w_reg    <= timeout;
      rd_w_reg         <= ex_mem_reg.rd;
      result_w_reg     <= result_next;
    end
  end

  assign Stall_M          = stall;
  assign dmem.req         = req;
  assign dmem.we          = req & ex_mem_reg.mem_write;
  assign dmem.addr        = {ex_mem_reg.alu_out[31:2], 2'b00};
  assign dmem.byte_en     = req ? lane_en : 4'b0000;
  assign dmem.wdata       = lane_wdata;
  assign Valid_W          = valid_w_reg;
  assign Reg_Write_W      = reg_write_w_reg;
  assign RD_W             = rd_w_reg;
  assign Result_W         = result_w_reg;
  assign Misaligned_Exc_W = misaligned_w_reg;
  assign Bus_Err_W        = bus_err_w_reg;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
  import memory_access_pkg::*;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Valid_E, Mem_Read_E, Mem_Write_E, Mem_Unsigned_E, Jump_E, Reg_Write_E;
  logic [1:0]  Mem_Size_E;
  logic [4:0]  RD_E;
  logic [31:0] ALU_Out_E, Store_Data_E, PC_Plus4_E;
  logic        Stall_M, Valid_W, Reg_Write_W, Misaligned_Exc_W, Bus_Err_W;
  logic [4:0]  RD_W;
  logic [31:0] Result_W;

  memory_access_if dmem ();

  memory_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .Valid_E          (Valid_E),
    .Mem_Read_E       (Mem_Read_E),
    .Mem_Write_E      (Mem_Write_E),
    .Mem_Size_E       (Mem_Size_E),
    .Mem_Unsigned_E   (Mem_Unsigned_E),
    .Jump_E           (Jump_E),
    .Reg_Write_E      (Reg_Write_E),
    .RD_E             (RD_E),
    .ALU_Out_E        (ALU_Out_E),
    .Store_Data_E     (Store_Data_E),
    .PC_Plus4_E       (PC_Plus4_E),
    .Stall_M          (Stall_M),
    .dmem             (dmem),
    .Valid_W          (Valid_W),
    .Reg_Write_W      (Reg_Write_W),
    .RD_W             (RD_W),
    .Result_W         (Result_W),
    .Misaligned_Exc_W (Misaligned_Exc_W),
    .Bus_Err_W        (Bus_Err_W)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit        valid, rd, wr;
    bit [1:0]  size;
    bit        uns, jump, rw;
    bit [4:0]  rdst;
    bit [31:0] alu, sdata, pc4, rdata;
    int        dly;      // cycle (from first M cycle) the ack arrives; -1 = never
    bit        spur;     // drive ack while no request is expected
    bit [1:0]  lit;      // 1 = literal result check, 2 = literal lane check
    bit [31:0] lit_res;
    bit [3:0]  lit_be;
    bit [31:0] lit_wd;
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Expectations published by the driver, consumed by the compare process.
  bit        chk = 1'b0, all_zero = 1'b0;
  bit        e_req, e_stall, e_we, e_vw, e_rw, e_mis, e_berr, e_res_en;
  bit [3:0]  e_be;
  bit [31:0] e_addr, e_wdata, e_res;
  bit [4:0]  e_rd;
  bit        lit_bus_en = 1'b0, lit_res_en = 1'b0;
  bit [3:0]  lit_be;
  bit [31:0] lit_wd, lit_res;

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input bit [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit [3:0] m_be(input bit [1:0] sz, input int a);
    int n;
    n = nbytes(sz);
    return 4'(((1 << n) - 1) << (n == 4 ? 0 : a));
  endfunction

  function automatic bit [31:0] m_wdata(input bit [1:0] sz, input bit [31:0] d);
    int n;
    n = nbytes(sz);
    if (n == 1) return 32'(d[7:0]) * 32'h0101_0101;
    if (n == 2) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit [31:0] m_load(input bit [31:0] rdata, input bit [1:0] sz,
                                       input int a, input bit uns);
    int n;
    bit [31:0] v, mask;
    n    = nbytes(sz);
    v    = rdata >> (8 * a);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = v & mask;
    if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- compare ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk) begin
      if (all_zero) begin
        check("zero Stall_M", 32'(Stall_M), 32'd0);
        check("zero DMEM_Req", 32'(dmem.req), 32'd0);
        check("zero DMEM_We", 32'(dmem.we), 32'd0);
        check("zero DMEM_Byte_En", 32'(dmem.byte_en), 32'd0);
        check("zero DMEM_Addr", dmem.addr, 32'd0);
        check("zero DMEM_WData", dmem.wdata, 32'd0);
        check("zero Valid_W", 32'(Valid_W), 32'd0);
        check("zero Reg_Write_W", 32'(Reg_Write_W), 32'd0);
        check("zero RD_W", 32'(RD_W), 32'd0);
        check("zero Result_W", Result_W, 32'd0);
        check("zero Misaligned_Exc_W", 32'(Misaligned_Exc_W), 32'd0);
        check("zero Bus_Err_W", 32'(Bus_Err_W), 32'd0);
      end else begin
        check("Stall_M", 32'(Stall_M), 32'(e_stall));
        check("DMEM_Req", 32'(dmem.req), 32'(e_req));
        if (e_req) begin
          check("DMEM_We", 32'(dmem.we), 32'(e_we));
          check("DMEM_Byte_En", 32'(dmem.byte_en), 32'(e_be));
          check("DMEM_Addr", dmem.addr, e_addr);
          check("DMEM_WData", dmem.wdata, e_wdata);
        end else begin
          check("idle DMEM_We", 32'(dmem.we), 32'd0);
          check("idle DMEM_Byte_En", 32'(dmem.byte_en), 32'd0);
        end
        check("Valid_W", 32'(Valid_W), 32'(e_vw));
        check("Reg_Write_W", 32'(Reg_Write_W), 32'(e_vw ? e_rw : 1'b0));
        if (e_vw) begin
          check("Misaligned_Exc_W", 32'(Misaligned_Exc_W), 32'(e_mis));
          check("Bus_Err_W", 32'(Bus_Err_W), 32'(e_berr));
          check("RD_W", 32'(RD_W), 32'(e_rd));
          if (e_res_en) check("Result_W", Result_W, e_res);
        end
        if (lit_bus_en) begin
          check("literal Byte_En", 32'(dmem.byte_en), 32'(lit_be));
          check("literal WData", dmem.wdata, lit_wd);
        end
        if (lit_res_en) check("literal Result_W", Result_W, lit_res);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_bubble();
    Valid_E = 1'b0; Mem_Read_E = 1'b0; Mem_Write_E = 1'b0; Mem_Size_E = 2'b00;
    Mem_Unsigned_E = 1'b0; Jump_E = 1'b0; Reg_Write_E = 1'b0; RD_E = 5'd0;
    ALU_Out_E = 32'd0; Store_Data_E = 32'd0; PC_Plus4_E = 32'd0;
  endtask

  task automatic drive_e(input txn_t t);
    Valid_E = t.valid; Mem_Read_E = t.rd; Mem_Write_E = t.wr; Mem_Size_E = t.size;
    Mem_Unsigned_E = t.uns; Jump_E = t.jump; Reg_Write_E = t.rw; RD_E = t.rdst;
    ALU_Out_E = t.alu; Store_Data_E = t.sdata; PC_Plus4_E = t.pc4;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_op(input int idx, input txn_t t);
    int  a, n, last;
    bit  alg, mem, tmo;
    a    = int'(t.alu[1:0]);
    n    = nbytes(t.size);
    alg  = (a % n) == 0;
    mem  = t.valid && (t.rd || t.wr) && alg;
    tmo  = mem && (t.dly < 0 || t.dly >= TMO);
    last = !mem ? 0 : (tmo ? TMO : t.dly);
    drive_e(t);
    step();
    drive_bubble();
    for (int c = 0; c <= last; c++) begin
      dmem.rdata = t.rdata;
      dmem.ack   = (mem && !tmo && c == last) || (t.spur && !mem);
      e_req      = mem && !(tmo && c == last);
      e_stall    = mem && c < last;
      e_we       = t.wr;
      e_be       = m_be(t.size, a);
      e_addr     = {t.alu[31:2], 2'b00};
      e_wdata    = m_wdata(t.size, t.sdata);
      e_vw       = 1'b0;
      lit_bus_en = (t.lit == 2'd2) && c == 0;
      lit_be     = t.lit_be;
      lit_wd     = t.lit_wd;
      step();
    end
    dmem.ack   = 1'b0;
    lit_bus_en = 1'b0;
    e_req      = 1'b0;
    e_stall    = 1'b0;
    e_vw       = t.valid;
    e_mis      = t.valid && (t.rd || t.wr) && !alg;
    e_berr     = tmo;
    e_rw       = t.valid && t.rw && !e_mis && !tmo;
    e_rd       = t.rdst;
    e_res_en   = t.valid && !e_mis && !tmo;
    e_res      = t.rd ? m_load(t.rdata, t.size, a, t.uns) : (t.jump ? t.pc4 : t.alu);
    lit_res_en = (t.lit == 2'd1);
    lit_res    = t.lit_res;
    step();
    lit_res_en = 1'b0;
    e_vw = 1'b0; e_rw = 1'b0; e_mis = 1'b0; e_berr = 1'b0; e_res_en = 1'b0;
    $display("txn %0d: addr=%h wait_cycles=%0d timeout=%0d checks=%0d failures=%0d",
             idx, t.alu, last, tmo, n_checks, n_fail);
  endtask

  txn_t txns [15];
  txn_t rt;

  initial begin
    //            v    rd   wr   size   uns  jmp  rw   rdst   alu           sdata         pc4           rdata         dly spur lit    lit_res       lit_be   lit_wd
    txns[0]  = '{1'b1,1'b0,1'b1,2'b10,1'b0,1'b0,1'b0,5'd0, 32'h0000_0104,32'hDEAD_BEEF,32'h0,       32'h0,         0,  1'b0,2'd2,32'h0,        4'b1111,32'hDEAD_BEEF};
    txns[1]  = '{1'b1,1'b1,1'b0,2'b00,1'b0,1'b0,1'b1,5'd5, 32'h0000_0203,32'h0,        32'h0,       32'h80FF_1234, 2,  1'b0,2'd1,32'hFFFF_FF80,4'b0000,32'h0};
    txns[2]  = '{1'b1,1'b1,1'b0,2'b00,1'b1,1'b0,1'b1,5'd6, 32'h0000_0203,32'h0,        32'h0,       32'h80FF_1234, 2,  1'b0,2'd1,32'h0000_0080,4'b0000,32'h0};
    txns[3]  = '{1'b1,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,5'd0, 32'h0000_0022,32'h0000_ABCD,32'h0,       32'h0,         1,  1'b0,2'd2,32'h0,        4'b1100,32'hABCD_ABCD};
    txns[4]  = '{1'b1,1'b1,1'b0,2'b01,1'b0,1'b0,1'b1,5'd8, 32'h0000_0021,32'h0,        32'h0,       32'h1234_5678, 0,  1'b0,2'd0,32'h0,        4'b0000,32'h0};
    txns[5]  = '{1'b1,1'b1,1'b0,2'b10,1'b0,1'b0,1'b1,5'd9, 32'h0000_0400,32'h0,        32'h0,       32'hCAFE_F00D,-1,  1'b0,2'd0,32'h0,        4'b0000,32'h0};
    txns[6]  = '{1'b1,1'b0,1'b0,2'b10,1'b0,1'b1,1'b1,5'd1, 32'h0000_0055,32'h0,        32'h0000_1008,32'h0,        0,  1'b1,2'd1,32'h0000_1008,4'b0000,32'h0};
    txns[7]  = '{1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,5'd7, 32'h1234_5678,32'h0,        32'h0,       32'h0,         0,  1'b0,2'd1,32'h1234_5678,4'b0000,32'h0};
    txns[8]  = '{1'b1,1'b1,1'b0,2'b01,1'b1,1'b0,1'b1,5'd10,32'h0000_0202,32'h0,        32'h0,       32'h80FF_1234, 1,  1'b0,2'd1,32'h0000_80FF,4'b0000,32'h0};
    txns[9]  = '{1'b1,1'b1,1'b0,2'b01,1'b0,1'b0,1'b1,5'd11,32'h0000_0202,32'h0,        32'h0,       32'h80FF_1234, 3,  1'b0,2'd1,32'hFFFF_80FF,4'b0000,32'h0};
    txns[10] = '{1'b1,1'b1,1'b0,2'b10,1'b0,1'b0,1'b1,5'd12,32'h0000_0208,32'h0,        32'h0,       32'h89AB_CDEF, 0,  1'b0,2'd1,32'h89AB_CDEF,4'b0000,32'h0};
    txns[11] = '{1'b1,1'b0,1'b1,2'b00,1'b0,1'b0,1'b0,5'd0, 32'h0000_0105,32'h1122_3344,32'h0,       32'h0,         1,  1'b0,2'd2,32'h0,        4'b0010,32'h4444_4444};
    txns[12] = '{1'b0,1'b1,1'b0,2'b10,1'b0,1'b0,1'b1,5'd13,32'h0000_0300,32'h0,        32'h0,       32'h0,         0,  1'b1,2'd0,32'h0,        4'b0000,32'h0};
    txns[13] = '{1'b1,1'b0,1'b1,2'b10,1'b0,1'b0,1'b0,5'd0, 32'h0000_010C,32'h0BAD_F00D,32'h0,       32'h0,         3,  1'b0,2'd0,32'h0,        4'b0000,32'h0};
    txns[14] = '{1'b1,1'b0,1'b1,2'b10,1'b0,1'b0,1'b0,5'd0, 32'h0000_0102,32'h5555_AAAA,32'h0,       32'h0,         0,  1'b0,2'd0,32'h0,        4'b0000,32'h0};

    // Reset, then confirm every output sits at zero.
    RST = 1'b1;
    drive_bubble();
    dmem.ack   = 1'b0;
    dmem.rdata = 32'd0;
    e_req = 1'b0; e_stall = 1'b0; e_we = 1'b0; e_vw = 1'b0; e_rw = 1'b0;
    e_mis = 1'b0; e_berr = 1'b0; e_res_en = 1'b0; e_be = 4'd0;
    e_addr = 32'd0; e_wdata = 32'd0; e_res = 32'd0; e_rd = 5'd0;
    step();
    step();
    RST = 1'b0;
    all_zero = 1'b1;
    chk = 1'b1;
    step();
    all_zero = 1'b0;
    $display("txn reset: checks=%0d failures=%0d", n_checks, n_fail);

    for (int i = 0; i < 15; i++) run_op(i, txns[i]);

    // Reset while a load is waiting; a late ack must not produce a writeback.
    rt = txns[5];
    rt.alu = 32'h0000_0300;
    drive_e(rt);
    step();
    drive_bubble();
    for (int c = 0; c < 2; c++) begin
      dmem.ack = 1'b0;
      e_req = 1'b1; e_stall = 1'b1; e_we = 1'b0; e_be = 4'b1111;
      e_addr = 32'h0000_0300; e_wdata = 32'd0; e_vw = 1'b0;
      step();
    end
    RST = 1'b1;
    e_req = 1'b0; e_stall = 1'b0;
    step();
    RST = 1'b0;
    dmem.ack = 1'b1;
    all_zero = 1'b1;
    step();
    dmem.ack = 1'b0;
    step();
    all_zero = 1'b0;
    $display("txn reset-in-wait: checks=%0d failures=%0d", n_checks, n_fail);

    // Pipeline carries on normally afterwards.
    run_op(15, txns[10]);

    chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
